program_loader: RTL and testbench



---
 rtl/program_loader.sv | 207 ++++++++++++++++++++
 tb/tb_program_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader for the Hack instruction ROM; holds the CPU in reset until the checksum verifies.
// Latency: each word is written (im_we pulse) the cycle after its low byte is accepted; cpu_reset falls RESET_HOLD cycles after the checksum byte.
// Backpressure: rx_ready is low only while releasing the CPU; bytes are taken on rx_valid && rx_ready.
// Ports: clk; reset (async, active-low); rx_data/rx_valid/rx_ready byte input;
//        im_d/im_address/im_we ROM write port; cpu_reset, done, error, error_code status.
module program_loader #(
    parameter int MAX_WORDS      = 32768,
    parameter int RESET_HOLD     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] im_d,
    output logic [14:0] im_address,
    output logic        im_we,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [16:0]       MAX_LEN   = 17'(MAX_WORDS);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO,
        ST_CHECK, ST_RELEASE, ST_DONE, ST_ERROR
    } state_t;

    state_t state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              im_we_q, im_we_d;
    logic [15:0]       im_d_q, im_d_d;
    logic [14:0]       im_address_q, im_address_d;
    logic              rx_ready_q, rx_ready_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        error_code_q, error_code_d;

    logic        accept;
    logic        in_frame;
    logic [15:0] len_new;
    logic [7:0]  sum_new;

    assign accept   = rx_valid && rx_ready_q;
    assign in_frame = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                      (state_q == ST_CHECK);
    assign len_new  = {len_q[15:8], rx_data};
    assign sum_new  = sum_q + rx_data;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            hi_q         <= '0;
            word_cnt_q   <= '0;
            sum_q        <= '0;
            to_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            im_we_q      <= 1'b0;
            im_d_q       <= '0;
            im_address_q <= '0;
            rx_ready_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            error_code_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            word_cnt_q   <= word_cnt_d;
            sum_q        <= sum_d;
            to_cnt_q     <= to_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            im_we_q      <= im_we_d;
            im_d_q       <= im_d_d;
            im_address_q <= im_address_d;
            rx_ready_q   <= rx_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
            error_code_q <= error_code_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        word_cnt_d   = word_cnt_q;
        sum_d        = sum_q;
        to_cnt_d     = to_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        im_we_d      = 1'b0;
        im_d_d       = im_d_q;
        im_address_d = im_address_q;
        error_code_d = error_code_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept && rx_data == 8'hA5) begin
                    state_d      = ST_LEN_HI;
                    error_code_d = 2'd0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d      = len_new;
                    word_cnt_d = '0;
                    sum_d      = '0;
                    if (len_new == 16'd0 || {1'b0, len_new} > MAX_LEN) begin
                        state_d      = ST_ERROR;
                        error_code_d = 2'd1;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    sum_d   = sum_new;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    im_we_d      = 1'b1;
                    im_d_d       = {hi_q, rx_data};
                    im_address_d = word_cnt_q[14:0];
                    word_cnt_d   = word_cnt_q + 16'd1;
                    sum_d        = sum_new;
                    state_d      = (word_cnt_q + 16'd1 == len_q) ? ST_CHECK : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (sum_new == 8'd0) begin
                        state_d    = ST_RELEASE;
                        hold_cnt_d = '0;
                    end else begin
                        state_d      = ST_ERROR;
                        error_code_d = 2'd2;
                    end
                end
            end
            ST_RELEASE: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte watchdog: counts idle cycles only while a frame is open.
        if (!in_frame || accept) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            state_d      = ST_ERROR;
            error_code_d = 2'd3;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Status outputs follow the state being entered, so they are registered with it.
    always_comb begin
        rx_ready_d  = (state_d != ST_RELEASE);
        cpu_reset_d = (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
    end

    assign rx_ready   = rx_ready_q;
    assign im_d       = im_d_q;
    assign im_address = im_address_q;
    assign im_we      = im_we_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign error_code = error_code_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    localparam int MAXW = 32768;
    localparam int HOLD = 4;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] im_d;
    logic [14:0] im_address;
    logic        im_we;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [1:0]  error_code;

    always #5 clk = ~clk;

    program_loader #(.MAX_WORDS(MAXW), .RESET_HOLD(HOLD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_d(im_d), .im_address(im_address), .im_we(im_we), .cpu_reset(cpu_reset),
        .done(done), .error(error), .error_code(error_code)
    );

    int errors = 0;
    int checks = 0;
    bit run_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph: 0 idle, 1 collecting a frame, 2 releasing, 3 done, 4 error
    int          ph;
    logic [7:0]  q[$];
    int          len, idle, hold, n, s;
    bit          acc;
    logic        m_rdy, m_we;
    logic [1:0]  m_code;
    logic [15:0] m_d;
    logic [14:0] m_addr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph = 0; q.delete(); idle = 0; hold = 0; len = 0;
            m_code = 0; m_we = 0; m_d = 0; m_addr = 0; m_rdy = 0;
        end else begin
            acc  = rx_valid && m_rdy;
            m_we = 0;
            if (ph == 1) begin
                if (acc) begin
                    q.push_back(rx_data);
                    idle = 0;
                    n = q.size();
                    if (n == 2) begin
                        len = {q[0], q[1]};
                        if (len == 0 || len > MAXW) begin ph = 4; m_code = 1; end
                    end else if (n >= 4 && n % 2 == 0 && n <= 2 + 2 * len) begin
                        m_we = 1; m_d = {q[n-2], q[n-1]}; m_addr = 15'((n - 4) / 2);
                    end else if (n == 3 + 2 * len) begin
                        s = 0;
                        for (int i = 2; i < n; i++) s += q[i];
                        if (s % 256 == 0) begin ph = 2; hold = 0; end
                        else begin ph = 4; m_code = 2; end
                    end
                end else begin
                    idle++;
                    if (idle == TO) begin ph = 4; m_code = 3; end
                end
            end else if (ph == 2) begin
                hold++;
                if (hold == HOLD) ph = 3;
            end else if (acc && rx_data == 8'hA5) begin
                ph = 1; q.delete(); idle = 0; m_code = 0;
            end
            m_rdy = (ph != 2);
        end
    end

    // ---------------- compare process ----------------
    logic [30:0] wlog[$];
    always @(negedge clk) begin
        if (run_chk) begin
            check("rx_ready",   rx_ready,   m_rdy);
            check("cpu_reset",  cpu_reset,  ph != 3);
            check("done",       done,       ph == 3);
            check("error",      error,      ph == 4);
            check("error_code", error_code, m_code);
            check("im_we",      im_we,      m_we);
            if (m_we) begin
                check("im_d",       im_d,       m_d);
                check("im_address", im_address, m_addr);
            end
        end
        if (im_we) wlog.push_back({im_address, im_d});
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b, input int gap);
        int w = 0;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && w < 40) begin @(posedge clk); #1; w++; end
        check("accept_wait_bound", w < 40, 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] f[$], input int from, input int to, input int maxgap);
        for (int i = from; i <= to; i++) send(f[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    endtask

    task automatic check_writes(input int base, input logic [15:0] words[$]);
        check("write_count", wlog.size() - base, words.size());
        for (int i = 0; i < words.size() && base + i < wlog.size(); i++)
            check("write_entry", wlog[base+i], {15'(i), words[i]});
    endtask

    task automatic expect_release();
        int c = 0;
        while (cpu_reset && c < 20) begin @(posedge clk); #1; c++; end
        check("release_delay", c, HOLD);
        check("done_after_release", done, 1);
    endtask

    task automatic check_reset_values();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_im_we", im_we, 0);
        check("rst_im_d", im_d, 0);
        check("rst_im_address", im_address, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_error_code", error_code, 0);
    endtask

    logic [7:0]  f1[$];
    logic [7:0]  f2[$];
    logic [15:0] w1[$];
    logic [15:0] w2[$];

    initial begin
        int base;
        int c;
        f1 = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h17,
               8'hE3, 8'h06, 8'h00, 8'h10, 8'hF2};
        w1 = '{16'h0002, 16'hEC10, 16'h0017, 16'hE306, 16'h0010};
        f2 = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        w2 = '{16'h1234, 16'hABCD};
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        #2 reset = 1'b0;
        #1 run_chk = 1;
        repeat (3) @(posedge clk);
        #1 check_reset_values();
        reset = 1'b1;
        @(posedge clk); #1;
        check("rx_ready_after_reset", rx_ready, 1);

        // 1: good frame, junk byte first
        send(8'h3C, 0);
        base = wlog.size();
        send_bytes(f1, 0, 13, 0);
        expect_release();
        check_writes(base, w1);

        // 2: bad checksum, reloaded from DONE
        base = wlog.size();
        f1[13] = 8'hF3;
        send_bytes(f1, 0, 13, 0);
        f1[13] = 8'hF2;
        check("csum_error", error, 1);
        check("csum_code", error_code, 2);
        check("csum_cpu_reset", cpu_reset, 1);
        check("csum_done", done, 0);
        check_writes(base, w1);

        // 3: bad lengths
        base = wlog.size();
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
        check("len0_code", error_code, 1);
        send(8'hA5, 0); send(8'h80, 0); send(8'h01, 0);
        check("lenmax_code", error_code, 1);
        check("len_no_writes", wlog.size(), base);

        // 4: stall after a DATA_HI byte
        send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0);
        c = 0;
        while (error_code != 2'd3 && c < 40) begin @(posedge clk); #1; c++; end
        check("timeout_cycles", c, TO);

        // 5: async reset after word 2, then full reload
        send_bytes(f1, 0, 6, 0);
        #2 reset = 1'b0;
        #1 check_reset_values();
        @(posedge clk); @(posedge clk); #1;
        check_reset_values();
        reset = 1'b1;
        send(8'h11, 1);
        base = wlog.size();
        send_bytes(f1, 0, 13, 0);
        expect_release();
        check_writes(base, w1);

        // 6: junk while DONE, reload with random gaps
        send(8'h5A, 2);
        check("done_ignores_junk", done, 1);
        base = wlog.size();
        send(8'hA5, 1);
        check("reload_cpu_reset", cpu_reset, 1);
        check("reload_done", done, 0);
        send_bytes(f2, 1, 7, 3);
        expect_release();
        check_writes(base, w2);

        repeat (4) @(posedge clk);
        #1 $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
